// File: rtl/multichannel_wave_gen.sv
// Multi-channel programmable on/off waveform generator with continuous and burst modes.
// Config lands in a per-channel shadow and is promoted to the active set only at a period boundary.
module multichannel_wave_gen #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [CHANNELS-1:0]  i_enable,
  input  logic                 i_cfg_valid,
  input  logic [3:0]           i_cfg_ch,
  input  logic [WIDTH-1:0]     i_cfg_on,
  input  logic [WIDTH-1:0]     i_cfg_off,
  input  logic                 i_cfg_burst,
  input  logic [CNT_WIDTH-1:0] i_cfg_count,
  output logic [CHANNELS-1:0]  o_data,
  output logic [CHANNELS-1:0]  o_busy,
  output logic [CHANNELS-1:0]  o_period_start,
  output logic [CHANNELS-1:0]  o_done
);

  // IDLE: stopped | ON: output high | OFF: output low | DONE: burst finished, waiting for enable low
  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_e;

  typedef struct packed {
    logic [WIDTH-1:0]     on;
    logic [WIDTH-1:0]     off;
    logic                 burst;
    logic [CNT_WIDTH-1:0] count;
  } cfg_t;

  localparam logic [WIDTH-1:0]     ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] ONE_C = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  cfg_t wr_cfg;
  assign wr_cfg = {i_cfg_on, i_cfg_off, i_cfg_burst, i_cfg_count};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e               state_q, state_d;
    logic [WIDTH-1:0]     phase_q, phase_d;
    logic [CNT_WIDTH-1:0] rem_q, rem_d;
    cfg_t                 act_q, act_d;
    cfg_t                 shd_q, shd_d;
    logic                 pend_q, pend_d;
    logic                 pstart_q, pstart_d;
    logic                 done_q, done_d;

    logic                 wr_hit;
    logic                 last_on;
    logic                 last_off;
    logic                 boundary;
    logic                 take_new;
    cfg_t                 cfg_eff;
    logic [WIDTH:0]       eff_period;

    assign wr_hit   = i_cfg_valid && (i_cfg_ch == 4'(g));
    assign last_on  = (state_q == S_ON)  && (phase_q == act_q.on - ONE_W);
    assign last_off = (state_q == S_OFF) && (phase_q == act_q.off - ONE_W);
    assign boundary = (last_on && (act_q.off == '0)) || last_off;
    // Stopped channels may take new config at any edge; running ones only on the boundary.
    assign take_new = boundary || (state_q == S_IDLE) || (state_q == S_DONE);

    always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      rem_d      = rem_q;
      act_d      = act_q;
      shd_d      = shd_q;
      pend_d     = pend_q;
      pstart_d   = 1'b0;
      done_d     = 1'b0;
      cfg_eff    = act_q;
      eff_period = '0;

      if (take_new && pend_q) begin
        cfg_eff = shd_q;
      end
      if (take_new && wr_hit) begin
        cfg_eff = wr_cfg;
      end
      eff_period = {1'b0, cfg_eff.on} + {1'b0, cfg_eff.off};

      if (wr_hit) begin
        shd_d  = wr_cfg;
        pend_d = 1'b1;
      end
      if (take_new) begin
        act_d  = cfg_eff;
        pend_d = 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (i_enable[g] && (eff_period != '0) &&
              !(cfg_eff.burst && (cfg_eff.count == '0))) begin
            state_d  = (cfg_eff.on != '0) ? S_ON : S_OFF;
            phase_d  = '0;
            rem_d    = cfg_eff.count;
            pstart_d = 1'b1;
          end
        end
        S_ON, S_OFF: begin
          if (!i_enable[g]) begin
            state_d = S_IDLE;
            phase_d = '0;
            rem_d   = '0;
          end else if (boundary) begin
            phase_d = '0;
            if (act_q.burst && (rem_q <= ONE_C)) begin
              state_d = S_DONE;
              rem_d   = '0;
              done_d  = 1'b1;
            end else if (eff_period == '0) begin
              state_d = S_IDLE;
            end else begin
              if (act_q.burst) begin
                rem_d = rem_q - ONE_C;
              end
              state_d  = (cfg_eff.on != '0) ? S_ON : S_OFF;
              pstart_d = 1'b1;
            end
          end else if (last_on) begin
            state_d = S_OFF;
            phase_d = '0;
          end else begin
            phase_d = phase_q + ONE_W;
          end
        end
        S_DONE: begin
          if (!i_enable[g]) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
        state_q  <= S_IDLE;
        phase_q  <= '0;
        rem_q    <= '0;
        act_q    <= '0;
        shd_q    <= '0;
        pend_q   <= 1'b0;
        pstart_q <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        phase_q  <= phase_d;
        rem_q    <= rem_d;
        act_q    <= act_d;
        shd_q    <= shd_d;
        pend_q   <= pend_d;
        pstart_q <= pstart_d;
        done_q   <= done_d;
      end
    end

    assign o_data[g]         = (state_q == S_ON);
    assign o_busy[g]         = (state_q == S_ON) || (state_q == S_OFF);
    assign o_period_start[g] = pstart_q;
    assign o_done[g]         = done_q;
  end

endmodule

// File: tb/tb_multichannel_wave_gen.sv
// Directed bench: a period-position model of every channel is checked each cycle,
// plus literal waveform snapshots that pin the model itself.
module tb_multichannel_wave_gen;
  localparam int WIDTH = 16;
  localparam int CH    = 4;
  localparam int CW    = 8;

  logic             i_clk = 1'b0;
  logic             i_reset_n = 1'b0;
  logic [CH-1:0]    i_enable = '0;
  logic             i_cfg_valid = 1'b0;
  logic [3:0]       i_cfg_ch = '0;
  logic [WIDTH-1:0] i_cfg_on = '0;
  logic [WIDTH-1:0] i_cfg_off = '0;
  logic             i_cfg_burst = 1'b0;
  logic [CW-1:0]    i_cfg_count = '0;
  logic [CH-1:0]    o_data, o_busy, o_period_start, o_done;

  multichannel_wave_gen #(.WIDTH(WIDTH), .CHANNELS(CH), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_cfg_valid(i_cfg_valid), .i_cfg_ch(i_cfg_ch), .i_cfg_on(i_cfg_on),
    .i_cfg_off(i_cfg_off), .i_cfg_burst(i_cfg_burst), .i_cfg_count(i_cfg_count),
    .o_data(o_data), .o_busy(o_busy), .o_period_start(o_period_start), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  // Model: each running channel is a position t inside a period of length on+off.
  typedef struct {int on; int off; int burst; int cnt;} mcfg_t;
  mcfg_t m_act[CH];
  mcfg_t m_shd[CH];
  int m_run[CH], m_hold[CH], m_donep[CH], m_t[CH], m_left[CH], m_pend[CH];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic model_step();
    mcfg_t w, nw, z;
    bit wr;
    int old_b;
    w.on = int'(i_cfg_on); w.off = int'(i_cfg_off);
    w.burst = int'(i_cfg_burst); w.cnt = int'(i_cfg_count);
    z.on = 0; z.off = 0; z.burst = 0; z.cnt = 0;
    for (int c = 0; c < CH; c++) m_donep[c] = 0;
    if (!i_reset_n) begin
      for (int c = 0; c < CH; c++) begin
        m_act[c] = z; m_shd[c] = z; m_run[c] = 0; m_hold[c] = 0;
        m_t[c] = 0; m_left[c] = 0; m_pend[c] = 0;
      end
      return;
    end
    for (int c = 0; c < CH; c++) begin
      wr = i_cfg_valid && (int'(i_cfg_ch) == c);
      if (m_run[c] != 0) begin
        if (!i_enable[c]) begin
          m_run[c] = 0;
          if (wr) begin m_shd[c] = w; m_pend[c] = 1; end
        end else if (m_t[c] == m_act[c].on + m_act[c].off - 1) begin
          old_b = m_act[c].burst;
          if (wr) nw = w;
          else if (m_pend[c] != 0) nw = m_shd[c];
          else nw = m_act[c];
          if (wr) m_shd[c] = w;
          m_act[c] = nw; m_pend[c] = 0; m_t[c] = 0;
          if (old_b != 0) m_left[c] = m_left[c] - 1;
          if (old_b != 0 && m_left[c] <= 0) begin
            m_run[c] = 0; m_hold[c] = 1; m_donep[c] = 1;
          end else if (nw.on + nw.off == 0) begin
            m_run[c] = 0;
          end
        end else begin
          m_t[c] = m_t[c] + 1;
          if (wr) begin m_shd[c] = w; m_pend[c] = 1; end
        end
      end else begin
        if (wr) begin m_act[c] = w; m_shd[c] = w; end
        else if (m_pend[c] != 0) m_act[c] = m_shd[c];
        m_pend[c] = 0;
        if (m_hold[c] != 0) begin
          if (!i_enable[c]) m_hold[c] = 0;
        end else if (i_enable[c] && (m_act[c].on + m_act[c].off > 0) &&
                     !(m_act[c].burst != 0 && m_act[c].cnt == 0)) begin
          m_run[c] = 1; m_t[c] = 0; m_left[c] = m_act[c].cnt;
        end
      end
    end
  endtask

  always @(posedge i_clk) model_step();

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic tick();
    logic [CH-1:0] ed, eb, ep, eo;
    @(negedge i_clk);
    if (chk_en) begin
      for (int c = 0; c < CH; c++) begin
        ed[c] = (m_run[c] != 0) && (m_t[c] < m_act[c].on);
        eb[c] = (m_run[c] != 0);
        ep[c] = (m_run[c] != 0) && (m_t[c] == 0);
        eo[c] = (m_donep[c] != 0);
      end
      cmp("model_data", 32'(o_data), 32'(ed));
      cmp("model_busy", 32'(o_busy), 32'(eb));
      cmp("model_pstart", 32'(o_period_start), 32'(ep));
      cmp("model_done", 32'(o_done), 32'(eo));
    end
  endtask

  task automatic grab(input int ch, input int n, output logic [31:0] d,
                      output logic [31:0] b, output logic [31:0] p, output logic [31:0] dn);
    d = '0; b = '0; p = '0; dn = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      d[i] = o_data[ch]; b[i] = o_busy[ch];
      p[i] = o_period_start[ch]; dn[i] = o_done[ch];
    end
  endtask

  task automatic wcfg(input int ch, input int on, input int off, input int burst, input int cnt);
    i_cfg_valid = 1'b1;
    i_cfg_ch    = 4'(ch);
    i_cfg_on    = 16'(on);
    i_cfg_off   = 16'(off);
    i_cfg_burst = 1'(burst);
    i_cfg_count = 8'(cnt);
    tick();
    i_cfg_valid = 1'b0;
  endtask

  logic [31:0] d, b, p, dn;

  initial begin
    tick(); tick();
    chk_en = 1'b1;
    cmp("reset_data", 32'(o_data), 32'h0);
    cmp("reset_busy", 32'(o_busy), 32'h0);
    i_reset_n = 1'b1;
    tick();

    // continuous 3/2
    wcfg(0, 3, 2, 0, 0);
    i_enable[0] = 1'b1;
    grab(0, 10, d, b, p, dn);
    cmp("cont_data", d, 32'b0011100111);
    cmp("cont_pstart", p, 32'b0000100001);
    i_enable[0] = 1'b0;
    tick(); tick();

    // burst of 3 at 1/1, then re-arm
    wcfg(1, 1, 1, 1, 3);
    i_enable[1] = 1'b1;
    grab(1, 10, d, b, p, dn);
    cmp("burst_data", d, 32'b0000010101);
    cmp("burst_busy", b, 32'b0000111111);
    cmp("burst_done", dn, 32'b0001000000);
    cmp("burst_pstart", p, 32'b0000010101);
    tick(); tick(); tick();
    i_enable[1] = 1'b0;
    tick();
    i_enable[1] = 1'b1;
    grab(1, 10, d, b, p, dn);
    cmp("rearm_data", d, 32'b0000010101);
    cmp("rearm_done", dn, 32'b0001000000);
    i_enable[1] = 1'b0;
    tick(); tick();

    // glitch-free update mid-ON, then a write exactly on the boundary edge
    wcfg(0, 4, 4, 0, 0);
    i_enable[0] = 1'b1;
    grab(0, 2, d, b, p, dn);
    wcfg(0, 1, 1, 0, 0);
    grab(0, 10, d, b, p, dn);
    cmp("update_data", d, 32'b1010100001);
    tick();
    wcfg(0, 2, 3, 0, 0);
    grab(0, 10, d, b, p, dn);
    cmp("bypass_data", d, 32'b1000110001);
    i_enable[0] = 1'b0;
    tick();

    // degenerate configurations
    wcfg(2, 0, 5, 0, 0);
    i_enable[2] = 1'b1;
    grab(2, 6, d, b, p, dn);
    cmp("on0_data", d, 32'h0);
    cmp("on0_busy", b, 32'b111111);
    cmp("on0_pstart", p, 32'b100001);
    i_enable[2] = 1'b0;
    tick();
    wcfg(3, 5, 0, 0, 0);
    i_enable[3] = 1'b1;
    grab(3, 8, d, b, p, dn);
    cmp("off0_data", d, 32'hFF);
    cmp("off0_pstart", p, 32'b00100001);
    i_enable[3] = 1'b0;
    tick();
    wcfg(2, 0, 0, 0, 0);
    i_enable[2] = 1'b1;
    grab(2, 4, d, b, p, dn);
    cmp("zero_busy", b, 32'h0);
    i_enable[2] = 1'b0;
    wcfg(3, 2, 2, 1, 0);
    i_enable[3] = 1'b1;
    grab(3, 6, d, b, p, dn);
    cmp("cnt0_busy", b, 32'h0);
    cmp("cnt0_done", dn, 32'h0);
    i_enable[3] = 1'b0;
    tick();

    // maximum-width fields
    wcfg(1, 16'hFFFF, 16'hFFFF, 0, 0);
    i_enable[1] = 1'b1;
    grab(1, 4, d, b, p, dn);
    cmp("max_data", d, 32'hF);
    for (int i = 0; i < 300; i++) tick();
    i_enable[1] = 1'b0;
    tick();
    wcfg(2, 16'h8000, 16'h8000, 0, 0);
    i_enable[2] = 1'b1;
    grab(2, 3, d, b, p, dn);
    cmp("sum_carry_busy", b, 32'b111);
    i_enable[2] = 1'b0;
    tick();

    // all channels in burst, out-of-range write, then reset mid-burst
    for (int c = 0; c < CH; c++) wcfg(c, 2, 1, 1, 5);
    wcfg(7, 1, 3, 0, 0);
    i_enable = 4'hF;
    grab(3, 6, d, b, p, dn);
    cmp("ch7_ignored_data", d, 32'b011011);
    cmp("ch7_ignored_pstart", p, 32'b001001);
    tick();
    i_reset_n = 1'b0;
    tick();
    cmp("rst_data", 32'(o_data), 32'h0);
    cmp("rst_busy", 32'(o_busy), 32'h0);
    cmp("rst_pstart", 32'(o_period_start), 32'h0);
    cmp("rst_done", 32'(o_done), 32'h0);
    tick();
    i_reset_n = 1'b1;
    tick(); tick(); tick();
    i_enable = '0;
    tick();

    // abort mid-ON
    wcfg(0, 6, 2, 1, 2);
    i_enable[0] = 1'b1;
    grab(0, 2, d, b, p, dn);
    cmp("abort_pre_data", d, 32'b11);
    i_enable[0] = 1'b0;
    grab(0, 6, d, b, p, dn);
    cmp("abort_data", d, 32'h0);
    cmp("abort_done", dn, 32'h0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
